// File: rtl/lcd_pkg.sv
// lcd_pkg: shared constants, colours, pattern codes and FSM states for the LCD pattern generator.
package lcd_pkg;
  localparam int H_RES_DEF = 240;
  localparam int V_RES_DEF = 135;
  localparam int CW = 9;
  typedef logic [15:0] rgb565_t;
  localparam rgb565_t C_WHITE   = 16'hFFFF;
  localparam rgb565_t C_YELLOW  = 16'hFFE0;
  localparam rgb565_t C_CYAN    = 16'h07FF;
  localparam rgb565_t C_GREEN   = 16'h07E0;
  localparam rgb565_t C_MAGENTA = 16'hF81F;
  localparam rgb565_t C_RED     = 16'hF800;
  localparam rgb565_t C_BLUE    = 16'h001F;
  localparam rgb565_t C_BLACK   = 16'h0000;
  localparam rgb565_t BAR_LUT [8] = '{C_WHITE, C_YELLOW, C_CYAN, C_GREEN, C_MAGENTA, C_RED, C_BLUE, C_BLACK};
  localparam logic [1:0] PAT_BARS  = 2'd0;
  localparam logic [1:0] PAT_CHECK = 2'd1;
  localparam logic [1:0] PAT_GRAD  = 2'd2;
  localparam logic [1:0] PAT_SOLID = 2'd3;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_STREAM} state_e;
endpackage

// File: rtl/lcd_pattern_gen_if.sv
// lcd_pattern_gen_if: pixel stream (valid/ready, RGB565 data, sof/eol/eof markers).
//   master drives pix_valid/pix_data/pix_sof/pix_eol/pix_eof and samples pix_ready; slave the reverse.
interface lcd_pattern_gen_if;
  logic        pix_valid;
  logic        pix_ready;
  logic [15:0] pix_data;
  logic        pix_sof;
  logic        pix_eol;
  logic        pix_eof;
  modport master(output pix_valid, pix_data, pix_sof, pix_eol, pix_eof, input pix_ready);
  modport slave(input pix_valid, pix_data, pix_sof, pix_eol, pix_eof, output pix_ready);
endinterface

// File: rtl/lcd_pattern_pixel.sv
// lcd_pattern_pixel: combinational RGB565 pixel for a coordinate.
//   x_i/y_i coordinate, bar_i colour-bar index, pat_i pattern code,
//   frame_cnt_i low frame-count bits (gradient blue), mod3_i frame count mod 3 (solid colour), pix_o pixel.
module lcd_pattern_pixel
  import lcd_pkg::*;
#(
  parameter int CHECK_SHIFT = 4
) (
  input  logic [CW-1:0] x_i,
  input  logic [CW-1:0] y_i,
  input  logic [2:0]    bar_i,
  input  logic [1:0]    pat_i,
  input  logic [4:0]    frame_cnt_i,
  input  logic [1:0]    mod3_i,
  output rgb565_t       pix_o
);
  logic unused_bits;
  assign unused_bits = ^{x_i, y_i};
  always_comb
    pix_o = pat_i == PAT_BARS  ? BAR_LUT[bar_i] :
            pat_i == PAT_CHECK ? ((x_i[CHECK_SHIFT] ^ y_i[CHECK_SHIFT]) ? C_WHITE : C_BLACK) :
            pat_i == PAT_GRAD  ? {x_i[7:3], y_i[5:0], frame_cnt_i} :
            mod3_i == 2'd0     ? C_RED :
            mod3_i == 2'd1     ? C_GREEN : C_BLUE;
endmodule

// File: rtl/lcd_pattern_gen.sv
// lcd_pattern_gen: raster test-pattern source feeding the ST7789 SPI stage.
//   clk/resetn clock and async active-low reset; enable runs frames; pattern_sel/auto_cycle choose the pattern;
//   pix master stream with frame/line markers; frame_cnt completed frames; busy frame in progress.
module lcd_pattern_gen
  import lcd_pkg::*;
#(
  parameter int H_RES          = H_RES_DEF,
  parameter int V_RES          = V_RES_DEF,
  parameter int BAR_W          = 30,
  parameter int CHECK_SHIFT    = 4,
  parameter int FRAMES_PER_PAT = 60
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 enable,
  input  logic [1:0]           pattern_sel,
  input  logic                 auto_cycle,
  lcd_pattern_gen_if.master    pix,
  output logic [15:0]          frame_cnt,
  output logic                 busy
);
  state_e state_q, state_d;
  logic [CW-1:0] x_q, x_d, y_q, y_d, bar_pos_q, bar_pos_d, nx, ny, nbar_pos, px, py;
  logic [2:0] bar_q, bar_d, nbar, pbar;
  logic [1:0] pat_q, pat_d, cur_pat_q, cur_pat_d, mod3_q, mod3_d, next_pat;
  logic [15:0] pat_frames_q, pat_frames_d, frame_cnt_q, frame_cnt_d;
  rgb565_t data_q, data_d, pix_next;
  logic streaming, xfer, last_x, last_y, bar_end, frame_done, pat_wrap;
  assign streaming  = state_q == S_STREAM;
  assign last_x     = x_q == CW'(H_RES - 1);
  assign last_y     = y_q == CW'(V_RES - 1);
  assign xfer       = streaming && pix.pix_ready;
  assign frame_done = xfer && last_x && last_y;
  assign bar_end    = bar_pos_q == CW'(BAR_W - 1);
  assign nx         = last_x ? '0 : x_q + 1'b1;
  assign ny         = last_x ? (last_y ? '0 : y_q + 1'b1) : y_q;
  assign nbar       = last_x ? '0 : bar_q + 3'(bar_end);
  assign nbar_pos   = (last_x || bar_end) ? '0 : bar_pos_q + 1'b1;
  // LOAD renders the current (0,0); STREAM pre-renders the pixel after the one on the bus.
  assign px = streaming ? nx : x_q;
  assign py = streaming ? ny : y_q;
  assign pbar = streaming ? nbar : bar_q;
  lcd_pattern_pixel #(.CHECK_SHIFT(CHECK_SHIFT)) u_pixel (
    .x_i(px), .y_i(py), .bar_i(pbar), .pat_i(pat_q),
    .frame_cnt_i(frame_cnt_q[4:0]), .mod3_i(mod3_q), .pix_o(pix_next)
  );
  assign pat_wrap     = pat_frames_q == 16'(FRAMES_PER_PAT - 1);
  assign pat_frames_d = !auto_cycle ? '0 : frame_done ? (pat_wrap ? '0 : pat_frames_q + 1'b1) : pat_frames_q;
  assign cur_pat_d    = cur_pat_q + 2'(auto_cycle && frame_done && pat_wrap);
  assign frame_cnt_d  = frame_cnt_q + 16'(frame_done);
  assign mod3_d       = frame_done ? (mod3_q == 2'd2 ? 2'd0 : mod3_q + 1'b1) : mod3_q;
  assign next_pat     = auto_cycle ? cur_pat_d : pattern_sel;
  always_comb begin
    state_d = state_q;
    x_d = x_q;
    y_d = y_q;
    bar_d = bar_q;
    bar_pos_d = bar_pos_q;
    pat_d = pat_q;
    data_d = data_q;
    case (state_q)
      S_IDLE: if (enable) begin
        state_d = S_LOAD;
        pat_d = next_pat;
      end
      S_LOAD: begin
        state_d = S_STREAM;
        data_d = pix_next;
      end
      S_STREAM: if (xfer) begin
        x_d = nx;
        y_d = ny;
        bar_d = nbar;
        bar_pos_d = nbar_pos;
        data_d = pix_next;
        if (frame_done) begin
          state_d = enable ? S_LOAD : S_IDLE;
          pat_d = next_pat;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge resetn)
    if (!resetn) begin
      state_q <= S_IDLE;
      x_q <= '0;
      y_q <= '0;
      bar_q <= '0;
      bar_pos_q <= '0;
      pat_q <= '0;
      cur_pat_q <= '0;
      pat_frames_q <= '0;
      frame_cnt_q <= '0;
      mod3_q <= '0;
      data_q <= '0;
    end else begin
      state_q <= state_d;
      x_q <= x_d;
      y_q <= y_d;
      bar_q <= bar_d;
      bar_pos_q <= bar_pos_d;
      pat_q <= pat_d;
      cur_pat_q <= cur_pat_d;
      pat_frames_q <= pat_frames_d;
      frame_cnt_q <= frame_cnt_d;
      mod3_q <= mod3_d;
      data_q <= data_d;
    end
  assign pix.pix_valid = streaming;
  assign pix.pix_data  = data_q;
  assign pix.pix_sof   = streaming && x_q == '0 && y_q == '0;
  assign pix.pix_eol   = streaming && last_x;
  assign pix.pix_eof   = streaming && last_x && last_y;
  assign frame_cnt     = frame_cnt_q;
  assign busy          = state_q != S_IDLE;
endmodule
